mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbiter and sequencer for a single shared multi-cycle memory port, used by instruction fetch (IF) and the MEM stage of the rv32i pipelined core.
- MEM stage request comes from the EX/MEM pipeline register outputs (mem_read/mem_write, alu_result as address, alu_in2 as write data).
- Serialises accesses over a req/ack bus.
- Returns read data to each requester.
- Generates per-stage stall signals so the hazard logic can freeze the pipeline until the access completes.

Parameters:
REGSIZE, 32, width of addresses and data.
STARVE_LIMIT, 4, maximum consecutive MEM grants while IF is waiting before IF is forced; legal range is 1 or more.

Ports:
clk  in  1  clock; all state updates on the rising edge
r  in  1  reset, asynchronous, active-high
if_req  in  1  IF requests a fetch; held until if_valid
if_addr  in  REGSIZE  fetch address (PC)
if_rdata  out  REGSIZE  fetched instruction, valid while if_valid=1
if_valid  out  1  one-cycle completion pulse for IF
mem_read  in  1  MEM stage load request (from EX/MEM)
mem_write  in  1  MEM stage store request (from EX/MEM)
mem_addr  in  REGSIZE  load/store address
mem_wdata  in  REGSIZE  store data
mem_rdata  out  REGSIZE  load data, valid while mem_done=1
mem_done  out  1  one-cycle completion pulse for MEM
stall_if  out  1  freeze IF/ID
stall_mem  out  1  freeze EX/MEM and earlier stages
bus_req  out  1  memory request
bus_we  out  1  1 = write
bus_addr  out  REGSIZE  memory address
bus_wdata  out  REGSIZE  memory write data
bus_rdata  in  REGSIZE  memory read data, sampled with bus_ack
bus_ack  in  1  memory completion, one cycle, only while bus_req=1

Behaviour:
- Reset (r=1, asynchronous): state=IDLE and starve_cnt=0. All registered outputs go to 0: bus_req, bus_we, bus_addr, bus_wdata, if_rdata, if_valid, mem_rdata, mem_done. Reset mid-transaction abandons the access immediately; no completion pulse is issued.
- States: IDLE, BUSY_IF, BUSY_MEM.
- mem_pend = mem_read | mem_write. If mem_read and mem_write are both 1, the access is a write.
- IDLE grant rule, evaluated on each edge. No grant is made in a cycle where if_valid or mem_done is 1; this is the turnaround cycle in which the requester consumes the result.
  - mem_pend and (!if_req or starve_cnt < STARVE_LIMIT) -> BUSY_MEM.
  - Otherwise if_req -> BUSY_IF.
  - Otherwise stay in IDLE.
- On the grant edge:
  - bus_req <= 1.
  - bus_addr, bus_we, bus_wdata latch from the granted requester. IF grants are reads with bus_wdata=0.
  - Bus outputs then hold constant until ack; later input changes are ignored.
- starve_cnt:
  - On a MEM grant with if_req=1: increment, saturating at STARVE_LIMIT.
  - On a MEM grant with if_req=0, or on any IF grant: clear to 0.
- BUSY_x, bus_ack=0: hold. There is no timeout.
- BUSY_x, bus_ack=1 at an edge:
  - bus_req <= 0, state <= IDLE.
  - For reads, the owner's rdata register <= bus_rdata. For writes, mem_rdata is unchanged.
  - The owner's valid/done <= 1 for exactly one cycle.
- bus_ack in IDLE is ignored.
- Minimum access latency: grant edge, then ack in the first bus_req cycle, then the done pulse on the next cycle. That is 2 cycles from grant to the done cycle; back-to-back accesses are spaced 3 cycles apart.
- if_rdata and mem_rdata hold their last value outside the valid/done pulse.
- Stall outputs are combinational:
  - stall_if = if_req & !if_valid.
  - stall_mem = mem_pend & !mem_done.
- Dropping a request while it is granted is illegal: the access still completes and the pulse still fires.

Test Plan:
- Reset: assert r asynchronously mid-cycle while in BUSY_MEM with bus_req=1 -> bus_req=0 before the next edge; no mem_done; state IDLE.
- Single load: mem_read=1, mem_addr=0x100, ack after 3 wait cycles with bus_rdata=0xDEADBEEF -> bus_we=0, bus_addr=0x100; mem_done pulses once; mem_rdata=0xDEADBEEF; stall_mem=1 until the done cycle.
- Store: mem_read=1 and mem_write=1, mem_wdata=0x12345678, addr=0x40 -> bus_we=1, bus_wdata=0x12345678; mem_done pulse; mem_rdata unchanged.
- Contention: if_req and mem_read both asserted in IDLE, immediate acks -> MEM granted first; IF granted after the turnaround cycle; if_valid follows mem_done by 3 cycles.
- Starvation: STARVE_LIMIT=4, if_req held, mem_pend re-asserted continuously -> 4 MEM grants, then 1 IF grant, then starve_cnt=0 and MEM is granted again.
- Stable bus: change mem_addr while in BUSY_MEM -> bus_addr keeps the latched value until ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for one shared multi-cycle memory port serving instruction
// fetch and the MEM stage, with bounded MEM priority so fetch cannot starve.
module mem_port_arbiter #(
  parameter int REGSIZE      = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               r,
  input  logic               if_req,
  input  logic [REGSIZE-1:0] if_addr,
  output logic [REGSIZE-1:0] if_rdata,
  output logic               if_valid,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [REGSIZE-1:0] mem_addr,
  input  logic [REGSIZE-1:0] mem_wdata,
  output logic [REGSIZE-1:0] mem_rdata,
  output logic               mem_done,
  output logic               stall_if,
  output logic               stall_mem,
  output logic               bus_req,
  output logic               bus_we,
  output logic [REGSIZE-1:0] bus_addr,
  output logic [REGSIZE-1:0] bus_wdata,
  input  logic [REGSIZE-1:0] bus_rdata,
  input  logic               bus_ack
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY_IF  = 2'd1;
  localparam logic [1:0] BUSY_MEM = 2'd2;

  localparam int              CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

  logic [1:0]         state_q,     state_d;
  logic [CW-1:0]      starve_q,    starve_d;
  logic               bus_req_q,   bus_req_d;
  logic               bus_we_q,    bus_we_d;
  logic [REGSIZE-1:0] bus_addr_q,  bus_addr_d;
  logic [REGSIZE-1:0] bus_wdata_q, bus_wdata_d;
  logic [REGSIZE-1:0] if_rdata_q,  if_rdata_d;
  logic               if_valid_q,  if_valid_d;
  logic [REGSIZE-1:0] mem_rdata_q, mem_rdata_d;
  logic               mem_done_q,  mem_done_d;

  logic mem_pend;
  logic turnaround;

  assign mem_pend   = mem_read | mem_write;
  // The requester consumes its result in the pulse cycle, so no grant then.
  assign turnaround = if_valid_q | mem_done_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d     = state_q;
    starve_d    = starve_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!turnaround) begin
          if (mem_pend && (!if_req || (starve_q < LIMIT))) begin
            state_d     = BUSY_MEM;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = mem_addr;
            bus_wdata_d = mem_wdata;
            if (!if_req)                starve_d = '0;
            else if (starve_q != LIMIT) starve_d = starve_q + CW'(1);
          end else if (if_req) begin
            state_d     = BUSY_IF;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr;
            bus_wdata_d = '0;
            starve_d    = '0;
          end
        end
      end
      BUSY_IF: begin
        if (bus_ack) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          if_rdata_d = bus_rdata;
          if_valid_d = 1'b1;
        end
      end
      BUSY_MEM: begin
        if (bus_ack) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          mem_done_d = 1'b1;
          if (!bus_we_q) mem_rdata_d = bus_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;

  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = mem_pend & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, load, store, contention,
// starvation bound, bus stability and asynchronous reset mid-access.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        r;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.REGSIZE(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .r(r),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] if_turn;
    r = 1'b1; if_req = 0; if_addr = 0; mem_read = 0; mem_write = 0;
    mem_addr = 0; mem_wdata = 0; bus_rdata = 0; bus_ack = 0;
    tick(); tick();
    check("rst_bus_req",   {31'd0, bus_req},   32'd0);
    check("rst_if_valid",  {31'd0, if_valid},  32'd0);
    check("rst_mem_done",  {31'd0, mem_done},  32'd0);
    check("rst_bus_addr",  bus_addr,           32'd0);
    check("rst_mem_rdata", mem_rdata,          32'd0);
    check("rst_stall_mem", {31'd0, stall_mem}, 32'd0);
    r = 1'b0;
    tick();

    // Single load with three wait cycles; address change mid-access is ignored.
    mem_read = 1; mem_addr = 32'h100;
    #1;
    check("ld_stall_pre", {31'd0, stall_mem}, 32'd1);
    tick();
    check("ld_bus_req",  {31'd0, bus_req}, 32'd1);
    check("ld_bus_we",   {31'd0, bus_we},  32'd0);
    check("ld_bus_addr", bus_addr,         32'h100);
    mem_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ld_wait_req",  {31'd0, bus_req},   32'd1);
      check("ld_wait_addr", bus_addr,           32'h100);
      check("ld_wait_done", {31'd0, mem_done},  32'd0);
      check("ld_wait_stall",{31'd0, stall_mem}, 32'd1);
    end
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    tick();
    check("ld_done",      {31'd0, mem_done},  32'd1);
    check("ld_rdata",     mem_rdata,          32'hDEADBEEF);
    check("ld_req_drop",  {31'd0, bus_req},   32'd0);
    check("ld_stall_off", {31'd0, stall_mem}, 32'd0);
    bus_ack = 0; mem_read = 0;
    tick();
    check("ld_done_once", {31'd0, mem_done}, 32'd0);
    check("ld_rdata_hold", mem_rdata,        32'hDEADBEEF);

    // Store with both read and write asserted: treated as a write.
    mem_read = 1; mem_write = 1; mem_addr = 32'h40; mem_wdata = 32'h12345678;
    bus_rdata = 32'hCAFEF00D;
    tick();
    check("st_bus_we",    {31'd0, bus_we}, 32'd1);
    check("st_bus_addr",  bus_addr,        32'h40);
    check("st_bus_wdata", bus_wdata,       32'h12345678);
    bus_ack = 1;
    tick();
    check("st_done",      {31'd0, mem_done}, 32'd1);
    check("st_rdata_keep", mem_rdata,        32'hDEADBEEF);
    bus_ack = 0; mem_read = 0; mem_write = 0;
    tick();

    // Ack while idle is ignored.
    bus_ack = 1;
    tick();
    check("idle_ack_done",  {31'd0, mem_done}, 32'd0);
    check("idle_ack_valid", {31'd0, if_valid}, 32'd0);
    bus_ack = 0;

    // Contention: MEM first, IF after the turnaround cycle.
    if_req = 1; if_addr = 32'h80; mem_read = 1; mem_addr = 32'h104;
    tick();
    check("ct_mem_addr", bus_addr,          32'h104);
    check("ct_stall_if", {31'd0, stall_if}, 32'd1);
    bus_ack = 1; bus_rdata = 32'h11111111;
    tick();
    check("ct_mem_done",  {31'd0, mem_done}, 32'd1);
    check("ct_mem_rdata", mem_rdata,         32'h11111111);
    bus_ack = 0; mem_read = 0;
    tick();
    check("ct_turn_req", {31'd0, bus_req}, 32'd0);
    tick();
    check("ct_if_req",   {31'd0, bus_req}, 32'd1);
    check("ct_if_addr",  bus_addr,         32'h80);
    check("ct_if_we",    {31'd0, bus_we},  32'd0);
    check("ct_if_wdata", bus_wdata,        32'd0);
    bus_ack = 1; bus_rdata = 32'h00000013;
    tick();
    check("ct_if_valid", {31'd0, if_valid}, 32'd1);
    check("ct_if_rdata", if_rdata,          32'h00000013);
    check("ct_if_stall", {31'd0, stall_if}, 32'd0);
    bus_ack = 0; if_req = 0;
    tick();
    check("ct_valid_once", {31'd0, if_valid}, 32'd0);

    // Starvation bound: four MEM grants, one IF grant, then MEM again.
    if_req = 1; if_addr = 32'h200; mem_read = 1; mem_addr = 32'h300;
    if_turn = 6'b010000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("sv_bus_addr", bus_addr, if_turn[i] ? 32'h200 : 32'h300);
      bus_ack = 1; bus_rdata = 32'hA0 + i;
      tick();
      check("sv_if_valid", {31'd0, if_valid}, {31'd0, if_turn[i]});
      check("sv_mem_done", {31'd0, mem_done}, {31'd0, ~if_turn[i]});
      bus_ack = 0;
      tick();
    end
    check("sv_if_rdata", if_rdata, 32'hA4);
    if_req = 0; mem_read = 0;
    tick();

    // Asynchronous reset mid-access abandons the transfer.
    mem_read = 1; mem_addr = 32'h500;
    tick();
    check("rs_granted", {31'd0, bus_req}, 32'd1);
    #2 r = 1'b1;
    #1;
    check("rs_req_low",  {31'd0, bus_req},  32'd0);
    check("rs_addr_clr", bus_addr,          32'd0);
    bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
    tick();
    check("rs_no_done",  {31'd0, mem_done}, 32'd0);
    r = 1'b0; bus_ack = 0; mem_read = 0;
    tick();
    check("rs_idle_req", {31'd0, bus_req},  32'd0);
    check("rs_idle_done",{31'd0, mem_done}, 32'd0);
    mem_read = 1; mem_addr = 32'h504;
    tick();
    check("rs_regrant",  bus_addr, 32'h504);
    bus_ack = 1; bus_rdata = 32'h55AA55AA;
    tick();
    check("rs_done",     {31'd0, mem_done}, 32'd1);
    check("rs_rdata",    mem_rdata,         32'h55AA55AA);
    bus_ack = 0; mem_read = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
